bias_bank_ctrl: RTL and testbench
=================================

# bias_bank_ctrl

Double-buffered bias scheduler for the bias stage of the systolic array. It accepts a stream of 16-bit bias scalars, one per column, into a shadow bank. On request it swaps that bank into the active bank that drives the per-column bias adders, so the next layer's biases load while the current layer is still running. A swap is held off while any column still has systolic data in flight, so one output row never mixes two layers' biases.

## Interface
- `N_COLS`, default 2: number of systolic columns, which equals the number of bias scalars per layer.
- `DATA_W`, default 16: signed fixed-point bias width, the same format as the bias adders.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `load_valid_in`  input  1: `load_data_in` holds a bias scalar.
- `load_data_in`  input  `DATA_W` (signed): bias scalar, sent column 0 first.
- `load_ready_out`  output  1: the shadow bank can accept a scalar.
- `load_done_out`  output  1: one-cycle pulse when the shadow bank becomes full.
- `swap_req_in`  input  1: one-cycle pulse requesting that the shadow bank be promoted.
- `swap_ack_out`  output  1: one-cycle pulse on the edge where the swap happens.
- `sys_valid_in`  input  `N_COLS`: per-column systolic valids, the same signals that feed the bias adders.
- `bias_scalar_out`  output  `N_COLS*DATA_W`: active bank; column c is `[c*DATA_W +: DATA_W]`.
- `bias_active_valid_out`  output  1: the active bank holds a loaded layer.

## Operation
- **States:**
  - `IDLE`: shadow bank empty.
  - `LOADING`: 1..`N_COLS`-1 words received.
  - `FULL`: shadow bank complete, waiting to swap.
- **Load rule:**
  - `load_ready_out` = 1 in `IDLE` and `LOADING`, 0 in `FULL`.
  - A word is accepted when `load_valid_in && load_ready_out`. It is written to `shadow[wr_cnt]` and `wr_cnt` increments.
  - Accepting a word in `IDLE` moves the FSM to `LOADING`. With `N_COLS`=1 it moves straight to `FULL`.
  - Accepting word `N_COLS`-1 moves the FSM to `FULL`, resets `wr_cnt` to 0 and pulses `load_done_out`.
- **Swap pending flag:**
  - `swap_req_in` sets `swap_pend` in any state.
  - Further requests while `swap_pend` is set are absorbed; the flag does not count.
- **Swap condition**, evaluated in a cycle:
  - state is `FULL`;
  - `swap_pend` is 1;
  - `sys_valid_in` == 0.
- **On a swap edge:**
  - active bank takes the shadow bank;
  - `bias_active_valid_out` goes to 1;
  - `swap_ack_out` pulses;
  - `swap_pend` clears;
  - FSM returns to `IDLE`.
- **Stalled swap:** if any `sys_valid_in` bit is 1, the swap waits, with no timeout.
- **Request on the swap cycle:** a `swap_req_in` pulse in the same cycle as a swap sets `swap_pend` again for the next layer.
- **Shadow contents:** not cleared on swap; the next load overwrites them.
- **Active bank:** changes only on a swap edge or on reset.
- **Arithmetic:** none; data passes through bit-exact.

## Timing
- **Reset values:**
  - `bias_scalar_out` = 0;
  - `bias_active_valid_out` = 0;
  - `load_done_out` = 0;
  - `swap_ack_out` = 0;
  - `load_ready_out` = 1, since reset enters `IDLE`;
  - internally: `wr_cnt` = 0, `swap_pend` = 0, shadow bank = 0.
- **Reset mid-load:** discards the partial shadow bank and any pending swap.
- **Load throughput:** one word per cycle. A full layer takes `N_COLS` accepted cycles.
- **`load_done_out`:** asserted in the first cycle the FSM is in `FULL`, i.e. registered off the last accept edge.
- **Earliest swap:** the first cycle in `FULL`, when `swap_pend` is already set and `sys_valid_in` == 0. `bias_scalar_out` changes on the following edge.
- **Swap latency:** a request arriving in `FULL` with the array idle gives `swap_ack_out` and the new biases one edge later.
- **Back-to-back layers:** after a swap, `load_ready_out` is 1 in the next cycle.
- **Output timing:**
  - all outputs are registered except `load_ready_out`, which is decoded combinationally from state;
  - `load_ready_out` has no combinational path from any input.

## Structure
- **Package `bias_ctrl_pkg`:**
  - state enum `{IDLE, LOADING, FULL}`;
  - default `DATA_W` and `N_COLS` constants;
  - a `$clog2`-sized counter width helper.
- **Sub-module `bias_bank`:** one instance for the shadow bank and one for the active bank. Each is an `N_COLS`×`DATA_W` register array with the same asynchronous reset and with indexed-write or full-parallel-load enables.
- **Top level:** FSM, `wr_cnt`, `swap_pend` and the output pulses.

## Test plan
1. **Reset:** assert `rst` mid-load after 1 word.
   - All outputs return to their reset values.
   - The next load starts at column 0.
2. **Load and swap:** `N_COLS`=2. Load 0x0100 then 0xFF80; `swap_req_in` in the cycle after `load_done_out`; `sys_valid_in`=0.
   - `swap_ack_out` one edge later.
   - `bias_scalar_out` = {0xFF80, 0x0100}.
   - `bias_active_valid_out` = 1.
3. **Stalled swap:** request arrives in `FULL` while `sys_valid_in`=2'b01 for 5 cycles.
   - No ack for those 5 cycles.
   - Ack on the first edge after `sys_valid_in` drops; the old active bank is held until then.
4. **Early request:** pulse `swap_req_in` in `IDLE`, then load 2 words.
   - Swap occurs in the first `FULL` cycle; exactly one ack.
5. **Back-pressure:** hold `load_valid_in`=1 with a third word in `FULL`.
   - `load_ready_out`=0 and the word is not taken.
   - After the swap, the word is accepted as column 0 of the next layer.
6. **Signed pass-through:** load 0x8000 and 0x7FFF, then swap.
   - The outputs match bit-exactly.

Source files
------------

// File: rtl/bias_bank_ctrl_pkg.sv
// Shared types and sizing helpers for the double-buffered bias scheduler.
package bias_ctrl_pkg;

    localparam int DEF_N_COLS = 2;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } state_e;

    // Column counter width; a single-column bank still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_bank_ctrl_if.sv
// Load/swap handshake and systolic-side signals of the bias scheduler.
interface bias_bank_ctrl_if #(
    parameter int N_COLS = 2,
    parameter int DATA_W = 16
);
    logic                     load_valid_in;
    logic signed [DATA_W-1:0] load_data_in;
    logic                     load_ready_out;
    logic                     load_done_out;
    logic                     swap_req_in;
    logic                     swap_ack_out;
    logic [N_COLS-1:0]        sys_valid_in;
    logic [N_COLS*DATA_W-1:0] bias_scalar_out;
    logic                     bias_active_valid_out;

    modport slave (
        input  load_valid_in, load_data_in, swap_req_in, sys_valid_in,
        output load_ready_out, load_done_out, swap_ack_out,
               bias_scalar_out, bias_active_valid_out
    );

    modport master (
        output load_valid_in, load_data_in, swap_req_in, sys_valid_in,
        input  load_ready_out, load_done_out, swap_ack_out,
               bias_scalar_out, bias_active_valid_out
    );
endinterface

// File: rtl/bias_bank_ctrl_bank.sv
// N_COLS x DATA_W register bank with indexed single-word write and full parallel load.
module bias_bank
    import bias_ctrl_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CW     = cnt_w(N_COLS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [CW-1:0]                  wr_idx,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           ld_en,
    input  logic [N_COLS-1:0][DATA_W-1:0]  ld_data,
    output logic [N_COLS-1:0][DATA_W-1:0]  q
);

    // Parallel load wins over the indexed write when both are raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int c = 0; c < N_COLS; c++) begin
                if (ld_en)
                    q[c] <= ld_data[c];
                else if (wr_en && wr_idx == CW'(c))
                    q[c] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/bias_bank_ctrl.sv
// Bias scheduler: fills a shadow bank word by word and promotes it to the
// active bank once a swap is requested and no column has data in flight.
module bias_bank_ctrl
    import bias_ctrl_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    bias_bank_ctrl_if.slave  bus
);

    localparam int CW = cnt_w(N_COLS);

    state_e                          state;
    logic [CW-1:0]                   wr_cnt;
    logic                            swap_pend;
    logic                            load_done;
    logic                            swap_ack;
    logic                            active_valid;
    logic [N_COLS-1:0][DATA_W-1:0]   shadow_q;
    logic [N_COLS-1:0][DATA_W-1:0]   active_q;

    logic accept;
    logic last;
    logic swap;

    // Ready depends only on state so upstream never sees a loop through us.
    assign bus.load_ready_out = (state != FULL);
    assign accept = bus.load_valid_in && bus.load_ready_out;
    assign last   = accept && (wr_cnt == CW'(N_COLS - 1));
    assign swap   = (state == FULL) && swap_pend && (bus.sys_valid_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            swap_pend    <= 1'b0;
            load_done    <= 1'b0;
            swap_ack     <= 1'b0;
            active_valid <= 1'b0;
        end else begin
            load_done <= last;
            swap_ack  <= swap;
            // A request coinciding with a swap re-arms for the next layer.
            swap_pend <= bus.swap_req_in | (swap_pend & ~swap);
            if (swap) begin
                state        <= IDLE;
                active_valid <= 1'b1;
            end else if (accept) begin
                state  <= last ? FULL : LOADING;
                wr_cnt <= last ? '0 : wr_cnt + CW'(1);
            end
        end
    end

    bias_bank #(.N_COLS(N_COLS), .DATA_W(DATA_W), .CW(CW)) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_idx  (wr_cnt),
        .wr_data (bus.load_data_in),
        .ld_en   (1'b0),
        .ld_data ('0),
        .q       (shadow_q)
    );

    bias_bank #(.N_COLS(N_COLS), .DATA_W(DATA_W), .CW(CW)) u_active (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (swap),
        .ld_data (shadow_q),
        .q       (active_q)
    );

    assign bus.bias_scalar_out       = active_q;
    assign bus.load_done_out         = load_done;
    assign bus.swap_ack_out          = swap_ack;
    assign bus.bias_active_valid_out = active_valid;

endmodule

// File: tb/tb_bias_bank_ctrl.sv
// Bench for bias_bank_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bias_bank_ctrl;

    localparam int N = 2;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bias_bank_ctrl_if #(.N_COLS(N), .DATA_W(W)) bus();
    bias_bank_ctrl #(.N_COLS(N), .DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow bank is a queue, full means it holds N words.
    logic [W-1:0] sh[$];
    logic [W-1:0] act_m[N];
    bit m_pend, m_done, m_ack, m_actv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh.delete();
            m_pend = 0; m_done = 0; m_ack = 0; m_actv = 0;
            foreach (act_m[i]) act_m[i] = '0;
        end else begin
            bit go;
            go = (sh.size() == N) && m_pend && (bus.sys_valid_in == '0);
            m_done = 0;
            m_ack  = go;
            if (go) begin
                foreach (act_m[i]) act_m[i] = sh[i];
                m_actv = 1;
                sh.delete();
                m_pend = bus.swap_req_in;
            end else begin
                m_pend = m_pend | bus.swap_req_in;
                if (bus.load_valid_in && sh.size() < N) begin
                    sh.push_back(bus.load_data_in);
                    if (sh.size() == N) m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [N*W-1:0] eb;
            for (int c = 0; c < N; c++) eb[c*W +: W] = act_m[c];
            chk("ready",  bus.load_ready_out,        sh.size() < N);
            chk("done",   bus.load_done_out,         m_done);
            chk("ack",    bus.swap_ack_out,          m_ack);
            chk("actv",   bus.bias_active_valid_out, m_actv);
            chk("bias",   bus.bias_scalar_out,       eb);
        end
    end

    task automatic drive(input bit lv, input logic [W-1:0] d, input bit req, input logic [N-1:0] sv);
        bus.load_valid_in = lv;
        bus.load_data_in  = d;
        bus.swap_req_in   = req;
        bus.sys_valid_in  = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bias"},  bus.bias_scalar_out, 0);
        chk({tag, "_actv"},  bus.bias_active_valid_out, 0);
        chk({tag, "_done"},  bus.load_done_out, 0);
        chk({tag, "_ack"},   bus.swap_ack_out, 0);
        chk({tag, "_ready"}, bus.load_ready_out, 1);
    endtask

    initial begin
        bus.load_valid_in = 0;
        bus.load_data_in  = '0;
        bus.swap_req_in   = 0;
        bus.sys_valid_in  = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst = 0;

        // Reset mid-load after one word
        drive(1, 16'h1234, 0, 0);
        chk("t1_ready", bus.load_ready_out, 1);
        rst = 1; #1;
        chk_reset_vals("t1");
        drive(0, 0, 0, 0);
        rst = 0;

        // Load and swap; the first load after reset must land in column 0
        drive(1, 16'h0100, 0, 0);
        chk("t2_done0", bus.load_done_out, 0);
        drive(1, 16'hFF80, 0, 0);
        chk("t2_done",  bus.load_done_out, 1);
        chk("t2_rdy0",  bus.load_ready_out, 0);
        drive(0, 0, 1, 0);
        chk("t2_ack0",  bus.swap_ack_out, 0);
        drive(0, 0, 0, 0);
        chk("t2_ack",   bus.swap_ack_out, 1);
        chk("t2_bias",  bus.bias_scalar_out, 32'hFF80_0100);
        chk("t2_actv",  bus.bias_active_valid_out, 1);
        chk("t2_rdy",   bus.load_ready_out, 1);
        drive(0, 0, 0, 0);
        chk("t2_ack1",  bus.swap_ack_out, 0);

        // Stalled swap while column 0 is busy
        drive(1, 16'h0011, 0, 0);
        drive(1, 16'h0022, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, (i == 0), 2'b01);
            chk("t3_noack", bus.swap_ack_out, 0);
            chk("t3_hold",  bus.bias_scalar_out, 32'hFF80_0100);
        end
        drive(0, 0, 0, 0);
        chk("t3_ack",  bus.swap_ack_out, 1);
        chk("t3_bias", bus.bias_scalar_out, 32'h0022_0011);

        // Early request in IDLE
        drive(0, 0, 1, 0);
        drive(1, 16'h0AAA, 0, 0);
        drive(1, 16'h0BBB, 0, 0);
        chk("t4_done", bus.load_done_out, 1);
        chk("t4_ack0", bus.swap_ack_out, 0);
        drive(0, 0, 0, 0);
        chk("t4_ack",  bus.swap_ack_out, 1);
        chk("t4_bias", bus.bias_scalar_out, 32'h0BBB_0AAA);
        drive(0, 0, 0, 0);
        chk("t4_once", bus.swap_ack_out, 0);

        // Back-pressure in FULL
        drive(1, 16'h0101, 0, 0);
        drive(1, 16'h0202, 0, 0);
        drive(1, 16'h0303, 0, 0);
        chk("t5_rdy0", bus.load_ready_out, 0);
        drive(1, 16'h0303, 1, 0);
        chk("t5_rdy1", bus.load_ready_out, 0);
        drive(1, 16'h0303, 0, 0);
        chk("t5_ack",  bus.swap_ack_out, 1);
        chk("t5_rdy2", bus.load_ready_out, 1);
        chk("t5_bias", bus.bias_scalar_out, 32'h0202_0101);
        drive(1, 16'h0303, 0, 0);
        drive(1, 16'h0404, 1, 0);
        drive(0, 0, 0, 0);
        chk("t5_ack2",  bus.swap_ack_out, 1);
        chk("t5_bias2", bus.bias_scalar_out, 32'h0404_0303);

        // Signed extremes
        drive(1, 16'h8000, 0, 0);
        drive(1, 16'h7FFF, 1, 0);
        drive(0, 0, 0, 0);
        chk("t6_bias", bus.bias_scalar_out, 32'h7FFF_8000);

        // Reset mid-load with a live active bank, then restart at column 0
        drive(1, 16'h5555, 0, 0);
        rst = 1; #1;
        chk_reset_vals("t7");
        drive(0, 0, 0, 0);
        rst = 0;
        drive(1, 16'h0001, 0, 0);
        drive(1, 16'h0002, 1, 0);
        drive(0, 0, 0, 0);
        chk("t7_bias", bus.bias_scalar_out, 32'h0002_0001);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 2) == 0) ? N'($urandom_range(1, 3)) : N'(0));
        end
        rst = 0;
        repeat (4) drive(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
